sram_like_arbiter: RTL and testbench

SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

---
 rtl/sram_like_arbiter.sv | 161 ++++++++++++++++
 tb/tb_sram_like_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_arbiter.sv
// Round-robin arbiter that merges several sram-like masters onto one in-order slave.
// An in-order ID FIFO routes each data_ok back to the master whose address was accepted.
module sram_like_arbiter #(
    parameter int unsigned NUM_MASTERS     = 2,
    parameter int unsigned ADDR_WD         = 32,
    parameter int unsigned DATA_WD         = 32,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_MASTERS-1:0]                m_req,
    input  logic [NUM_MASTERS-1:0]                m_wr,
    input  logic [2*NUM_MASTERS-1:0]              m_size,
    input  logic [NUM_MASTERS*(DATA_WD/8)-1:0]    m_wstrb,
    input  logic [NUM_MASTERS*ADDR_WD-1:0]        m_addr,
    input  logic [NUM_MASTERS*DATA_WD-1:0]        m_wdata,
    output logic [NUM_MASTERS-1:0]                m_addr_ok,
    output logic [NUM_MASTERS-1:0]                m_data_ok,
    output logic [DATA_WD-1:0]                    m_rdata,
    output logic                                  s_req,
    output logic                                  s_wr,
    output logic [1:0]                            s_size,
    output logic [DATA_WD/8-1:0]                  s_wstrb,
    output logic [ADDR_WD-1:0]                    s_addr,
    output logic [DATA_WD-1:0]                    s_wdata,
    input  logic                                  s_addr_ok,
    input  logic                                  s_data_ok,
    input  logic [DATA_WD-1:0]                    s_rdata,
    output logic [$clog2(MAX_OUTSTANDING):0]      outstanding,
    output logic                                  err_unexpected
);

    localparam int unsigned STRB_W = DATA_WD / 8;
    localparam int unsigned ID_W   = $clog2(NUM_MASTERS);
    localparam int unsigned PTR_W  = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CNT_W  = PTR_W + 1;

    typedef enum logic {
        ST_FREE   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_e;

    lock_state_e       r_state;
    lock_state_e       w_state_nxt;
    logic [ID_W-1:0]   r_lock_id;
    logic [ID_W-1:0]   w_lock_id_nxt;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ID_W-1:0]   w_grant;
    logic              w_any;
    logic              w_full;
    logic              w_empty;
    logic              w_hs;
    logic              w_pop;
    int unsigned       w_best;
    int unsigned       w_off;

    logic [ID_W-1:0]   r_fifo [MAX_OUTSTANDING];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_err;

    // Grant: locked id wins outright, else the requester nearest at/after rr_ptr
    always_comb begin
        w_grant = '0;
        w_any   = 1'b0;
        w_best  = NUM_MASTERS;
        w_off   = 0;
        if (r_state == ST_LOCKED) begin
            w_grant = r_lock_id;
            w_any   = 1'b1;
        end else begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                w_off = (32'(i) + NUM_MASTERS - 32'(r_rr_ptr)) % NUM_MASTERS;
                if (m_req[i] && (w_off < w_best)) begin
                    w_best  = w_off;
                    w_grant = ID_W'(i);
                    w_any   = 1'b1;
                end
            end
        end
    end

    assign w_full  = (r_count == CNT_W'(MAX_OUTSTANDING));
    assign w_empty = (r_count == '0);
    assign s_req   = w_any & ~w_full & ~reset;
    assign w_hs    = s_req & s_addr_ok;
    assign w_pop   = s_data_ok & ~w_empty & ~reset;

    assign m_rdata        = s_rdata;
    assign outstanding    = r_count;
    assign err_unexpected = r_err;

    always_comb begin
        s_wr    = 1'b0;
        s_size  = '0;
        s_wstrb = '0;
        s_addr  = '0;
        s_wdata = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            m_addr_ok[i] = w_hs && (w_grant == ID_W'(i));
            m_data_ok[i] = w_pop && (r_fifo[r_rptr] == ID_W'(i));
            if (w_grant == ID_W'(i)) begin
                s_wr    = m_wr[i];
                s_size  = m_size[2*i +: 2];
                s_wstrb = m_wstrb[i*STRB_W +: STRB_W];
                s_addr  = m_addr[i*ADDR_WD +: ADDR_WD];
                s_wdata = m_wdata[i*DATA_WD +: DATA_WD];
            end
        end
    end

    // Lock holds the grant across a stalled address phase
    always_comb begin
        w_state_nxt   = r_state;
        w_lock_id_nxt = r_lock_id;
        if (w_hs) begin
            w_state_nxt = ST_FREE;
        end else if (s_req) begin
            w_state_nxt   = ST_LOCKED;
            w_lock_id_nxt = w_grant;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_FREE;
            r_lock_id <= '0;
            r_rr_ptr  <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_lock_id <= w_lock_id_nxt;
            if (w_hs) begin
                r_rr_ptr <= (w_grant == ID_W'(NUM_MASTERS - 1)) ? '0 : w_grant + ID_W'(1);
                r_wptr   <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            if (w_hs && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_hs && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (s_data_ok && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_hs) begin
            r_fifo[r_wptr] <= w_grant;
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Randomized and directed bench for sram_like_arbiter against a queue-based reference model.
module tb_sram_like_arbiter;

    localparam int unsigned N  = 2;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned MO = 4;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned CW = $clog2(MO) + 1;

    logic              clk;
    logic              reset;
    logic [N-1:0]      m_req;
    logic [N-1:0]      m_wr;
    logic [2*N-1:0]    m_size;
    logic [N*SW-1:0]   m_wstrb;
    logic [N*AW-1:0]   m_addr;
    logic [N*DW-1:0]   m_wdata;
    logic [N-1:0]      m_addr_ok;
    logic [N-1:0]      m_data_ok;
    logic [DW-1:0]     m_rdata;
    logic              s_req;
    logic              s_wr;
    logic [1:0]        s_size;
    logic [SW-1:0]     s_wstrb;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_wdata;
    logic              s_addr_ok;
    logic              s_data_ok;
    logic [DW-1:0]     s_rdata;
    logic [CW-1:0]     outstanding;
    logic              err_unexpected;

    sram_like_arbiter #(
        .NUM_MASTERS(N), .ADDR_WD(AW), .DATA_WD(DW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .reset(reset),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
        .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
        .s_addr(s_addr), .s_wdata(s_wdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
        .outstanding(outstanding), .err_unexpected(err_unexpected)
    );

    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Reference model: accepted master ids in order, rotation pointer, locked id (-1 none)
    int q[$];
    int rr;
    int lk;
    bit merr;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic [N-1:0] req, input logic aok, input logic dok,
                        input logic [DW-1:0] rdata, input logic rst);
        int g;
        bit any;
        bit sreq;
        bit hs;
        bit pop;
        logic [N-1:0] eaok;
        logic [N-1:0] edok;
        @(negedge clk);
        reset     = rst;
        m_req     = req;
        s_addr_ok = aok;
        s_data_ok = dok;
        s_rdata   = rdata;
        for (int i = 0; i < N; i++) begin
            m_wr[i]               = 1'($urandom);
            m_size[2*i +: 2]      = 2'($urandom);
            m_wstrb[i*SW +: SW]   = SW'($urandom);
            m_addr[i*AW +: AW]    = AW'($urandom);
            m_wdata[i*DW +: DW]   = DW'($urandom);
        end
        #1;
        g   = 0;
        any = 0;
        if (lk >= 0) begin
            g   = lk;
            any = 1;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!any && req[(rr + k) % N]) begin
                    g   = (rr + k) % N;
                    any = 1;
                end
            end
        end
        sreq = any && (q.size() < MO) && !rst;
        hs   = sreq && aok;
        pop  = !rst && dok && (q.size() > 0);
        eaok = hs ? (N'(1) << g) : '0;
        edok = pop ? (N'(1) << q[0]) : '0;

        chk("s_req", 64'(s_req), 64'(sreq));
        chk("m_addr_ok", 64'(m_addr_ok), 64'(eaok));
        chk("m_data_ok", 64'(m_data_ok), 64'(edok));
        chk("m_rdata", 64'(m_rdata), 64'(rdata));
        chk("outstanding", 64'(outstanding), 64'(q.size()));
        chk("err_unexpected", 64'(err_unexpected), 64'(merr));
        if (sreq) begin
            chk("s_addr", 64'(s_addr), 64'(m_addr[g*AW +: AW]));
            chk("s_wdata", 64'(s_wdata), 64'(m_wdata[g*DW +: DW]));
            chk("s_ctrl", 64'({s_wr, s_size, s_wstrb}),
                64'({m_wr[g], m_size[2*g +: 2], m_wstrb[g*SW +: SW]}));
        end

        if (rst) begin
            q.delete();
            rr   = 0;
            lk   = -1;
            merr = 0;
        end else begin
            if (dok && q.size() == 0) merr = 1;
            if (pop) void'(q.pop_front());
            if (hs) begin
                q.push_back(g);
                rr = (g + 1) % N;
                lk = -1;
            end else if (sreq) begin
                lk = g;
            end
        end
    endtask

    initial begin
        clk = 1'b0;
        reset = 1'b1;
        m_req = '0; m_wr = '0; m_size = '0; m_wstrb = '0; m_addr = '0; m_wdata = '0;
        s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = '0;
        n_vec = 0; n_err = 0;
        q.delete(); rr = 0; lk = -1; merr = 0;
        repeat (2) @(posedge clk);
        step('0, 1'b0, 1'b0, '0, 1'b1);

        // Simultaneous requests alternate 0,1,0
        step(2'b11, 1'b1, 1'b0, '0, 1'b0); chk("rr_c0", 64'(m_addr_ok), 64'(2'b01));
        step(2'b11, 1'b1, 1'b0, '0, 1'b0); chk("rr_c1", 64'(m_addr_ok), 64'(2'b10));
        step(2'b11, 1'b1, 1'b0, '0, 1'b0); chk("rr_c2", 64'(m_addr_ok), 64'(2'b01));
        repeat (3) step('0, 1'b0, 1'b1, DW'($urandom), 1'b0);

        // Lock holds master 0 while master 1 joins
        step(2'b01, 1'b0, 1'b0, '0, 1'b0); chk("lock_a0", 64'(s_addr), 64'(m_addr[AW-1:0]));
        step(2'b11, 1'b0, 1'b0, '0, 1'b0); chk("lock_a1", 64'(s_addr), 64'(m_addr[AW-1:0]));
        step(2'b11, 1'b0, 1'b0, '0, 1'b0); chk("lock_a2", 64'(s_addr), 64'(m_addr[AW-1:0]));
        step(2'b11, 1'b1, 1'b0, '0, 1'b0); chk("lock_acc", 64'(m_addr_ok), 64'(2'b01));
        step(2'b11, 1'b1, 1'b0, '0, 1'b0); chk("lock_next", 64'(m_addr_ok), 64'(2'b10));

        // Ordering of responses
        step('0, 1'b0, 1'b0, '0, 1'b1);
        step(2'b10, 1'b1, 1'b0, '0, 1'b0); chk("ord_acc1", 64'(m_addr_ok), 64'(2'b10));
        step(2'b01, 1'b1, 1'b0, '0, 1'b0); chk("ord_acc0", 64'(m_addr_ok), 64'(2'b01));
        step('0, 1'b0, 1'b1, 32'hAAAA0001, 1'b0);
        chk("ord_dok1", 64'(m_data_ok), 64'(2'b10));
        chk("ord_rd1", 64'(m_rdata), 64'(32'hAAAA0001));
        step('0, 1'b0, 1'b1, 32'hBBBB0000, 1'b0);
        chk("ord_dok0", 64'(m_data_ok), 64'(2'b01));
        chk("ord_rd0", 64'(m_rdata), 64'(32'hBBBB0000));

        // Full FIFO blocks s_req even alongside a pop
        repeat (4) step(2'b11, 1'b1, 1'b0, '0, 1'b0);
        step(2'b11, 1'b1, 1'b0, '0, 1'b0);
        chk("full_sreq", 64'(s_req), 64'(0));
        chk("full_cnt", 64'(outstanding), 64'(4));
        step(2'b11, 1'b1, 1'b1, '0, 1'b0);
        chk("full_pop_sreq", 64'(s_req), 64'(0));
        step(2'b11, 1'b1, 1'b0, '0, 1'b0);
        chk("after_pop_sreq", 64'(s_req), 64'(1));
        chk("after_pop_acc", 64'(m_addr_ok), 64'(2'b10));
        chk("after_pop_cnt", 64'(outstanding), 64'(3));

        // Simultaneous push/pop keeps occupancy and wraps pointers
        repeat (2) step('0, 1'b0, 1'b1, '0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(2'b11, 1'b1, 1'b1, DW'($urandom), 1'b0);
            chk("pushpop_cnt", 64'(outstanding), 64'(2));
        end

        // Spurious data_ok and reset recovery
        repeat (2) step('0, 1'b0, 1'b1, '0, 1'b0);
        step('0, 1'b0, 1'b1, '0, 1'b0); chk("spur_dok", 64'(m_data_ok), 64'(0));
        step('0, 1'b0, 1'b0, '0, 1'b0); chk("spur_err", 64'(err_unexpected), 64'(1));
        step('0, 1'b0, 1'b0, '0, 1'b0); chk("spur_hold", 64'(err_unexpected), 64'(1));
        repeat (3) step(2'b11, 1'b1, 1'b0, '0, 1'b0);
        step('0, 1'b0, 1'b0, '0, 1'b1); chk("rst_pre_cnt", 64'(outstanding), 64'(3));
        step('0, 1'b0, 1'b0, '0, 1'b0);
        chk("rst_cnt", 64'(outstanding), 64'(0));
        chk("rst_err", 64'(err_unexpected), 64'(0));

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(N'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                 DW'($urandom), ($urandom_range(0, 99) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
